// File: rtl/conv_seq_c6_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | conv_seq_c6_if : control/data bundle of the 6-lane conv sequencer |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface conv_seq_c6_if #(
    parameter int N  = 16,
    parameter int AW = 5
);
    logic          start;
    logic          busy;
    logic          tap_rd;
    logic [AW-1:0] tap_addr;
    logic          psum_vld;
    logic [31:0]   psum_din;
    logic [31:0]   bias_din;
    logic [4:0]    shift_din;
    logic [N-1:0]  dout;
    logic          dout_vld;
    logic          dout_rdy;
    logic          done;

    modport master (
        output start, psum_vld, psum_din, bias_din, shift_din, dout_rdy,
        input  busy, tap_rd, tap_addr, dout, dout_vld, done
    );

    modport slave (
        input  start, psum_vld, psum_din, bias_din, shift_din, dout_rdy,
        output busy, tap_rd, tap_addr, dout, dout_vld, done
    );
endinterface
`default_nettype wire

// File: rtl/conv_seq_c6.sv
`default_nettype none
// +------------------------------------------------------------------+
// | conv_seq_c6 : per-pixel tap sequencer, psum accumulator, bias,   |
// | shift and ReLU; CONV_SEQ_SAT_EN adds positive saturation.        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module conv_seq_c6 #(
    parameter int N     = 16,
    parameter int KTAPS = 25,
    parameter int AW    = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    conv_seq_c6_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_DRAIN = 3'd2,
        S_POST  = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    localparam int            c_RW       = AW + 1;
    localparam logic [AW-1:0] c_LAST_TAP = AW'(KTAPS - 1);
    localparam logic [c_RW-1:0] c_KTAPS  = c_RW'(KTAPS);
`ifdef CONV_SEQ_SAT_EN
    localparam logic [31:0]   c_SAT_MAX  = 32'((64'd1 << (N - 1)) - 64'd1);
`endif

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_issue;
    logic [c_RW-1:0] r_ret;
    logic [31:0]     r_acc;
    logic [N-1:0]    r_dout;
    logic [31:0]     w_sum;
    logic [N-1:0]    w_result;
    logic            w_accept;
    logic            w_launch;
`ifdef CONV_SEQ_SAT_EN
    logic [31:0]     w_shr;
`endif

    assign w_launch = (r_state == S_IDLE) && bus.start;
    // Returns are counted in any active state, but only the first KTAPS.
    assign w_accept = (r_state != S_IDLE) && bus.psum_vld && (r_ret < c_KTAPS);
    assign w_sum    = r_acc + bus.bias_din;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start)              w_state_nxt = S_ISSUE;
            S_ISSUE: if (r_issue == c_LAST_TAP)  w_state_nxt = S_DRAIN;
            S_DRAIN: if (r_ret == c_KTAPS)       w_state_nxt = S_POST;
            S_POST:                              w_state_nxt = S_OUT;
            S_OUT:   if (bus.dout_rdy)           w_state_nxt = S_IDLE;
            default:                             w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_result = '0;
`ifdef CONV_SEQ_SAT_EN
        w_shr = w_sum >> bus.shift_din;
        if (!w_sum[31]) begin
            w_result = (w_shr > c_SAT_MAX) ? c_SAT_MAX[N-1:0] : w_shr[N-1:0];
        end
`else
        if (!w_sum[31]) begin
            w_result = N'(w_sum >> bus.shift_din);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_issue <= '0;
            r_ret   <= '0;
            r_acc   <= '0;
            r_dout  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_launch) begin
                r_issue <= '0;
                r_ret   <= '0;
                r_acc   <= '0;
            end else begin
                if ((r_state == S_ISSUE) && (r_issue != c_LAST_TAP)) begin
                    r_issue <= r_issue + 1'b1;
                end
                if (w_accept) begin
                    r_acc <= r_acc + bus.psum_din;
                    r_ret <= r_ret + 1'b1;
                end
            end
            if (r_state == S_POST) begin
                r_dout <= w_result;
            end
        end
    end

    assign bus.busy     = (r_state != S_IDLE);
    assign bus.tap_rd   = (r_state == S_ISSUE);
    assign bus.tap_addr = r_issue;
    assign bus.dout     = r_dout;
    assign bus.dout_vld = (r_state == S_OUT);
    assign bus.done     = (r_state == S_OUT) && bus.dout_rdy;
endmodule
`default_nettype wire

// File: tb/tb_conv_seq_c6.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_conv_seq_c6 : randomized bench with a delayed-echo psum       |
// | datapath and an arithmetic reference model.  Rev 1.0             |
// +------------------------------------------------------------------+
module tb_conv_seq_c6;
    localparam int N  = 16;
    localparam int K  = 4;
    localparam int AW = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    conv_seq_c6_if #(.N(N), .AW(AW)) bus ();

    conv_seq_c6 #(.N(N), .KTAPS(K), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    logic rst_q;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst_n;
    end

    int           n_started = 0;
    int           n_done    = 0;
    int           n_abort   = 0;
    int           start_cyc = 0;
    int           cur_L     = 1;
    logic [N-1:0] exp_dout  = '0;
    logic [31:0]  psum_tab [K];
    logic         idle_junk = 1'b0;
    int           checks    = 0;
    int           errors    = 0;

    function automatic logic [N-1:0] model(input longint acc, input longint bias, input int sh);
        longint s;
        longint r;
        s = (acc + bias) & 64'h0000_0000_FFFF_FFFF;
        if (s >= 64'h0000_0000_8000_0000) return '0;
        r = s / (longint'(1) << sh);
`ifdef CONV_SEQ_SAT_EN
        if (r > (longint'(1) << (N - 1)) - 1) return N'((longint'(1) << (N - 1)) - 1);
`endif
        return N'(r);
    endfunction

    // Datapath stand-in: each tap read comes back cur_L cycles later.
    logic [7:0]    hist_rd = '0;
    logic [AW-1:0] hist_addr [8];
    always @(negedge clk) begin
        hist_rd[cyc % 8]   <= bus.tap_rd;
        hist_addr[cyc % 8] <= bus.tap_addr;
    end

    initial begin : emu
        int emu_ret;
        int emu_pix;
        int e;
        emu_ret      = 0;
        emu_pix      = 0;
        bus.psum_vld = 1'b0;
        bus.psum_din = '0;
        forever begin
            @(posedge clk);
            #2;
            if (n_started != emu_pix) begin
                emu_pix = n_started;
                emu_ret = 0;
            end
            e            = cyc - cur_L;
            bus.psum_vld = 1'b0;
            bus.psum_din = $urandom;
            if (e >= 0 && hist_rd[e % 8]) begin
                bus.psum_vld = 1'b1;
                bus.psum_din = psum_tab[hist_addr[e % 8]];
                emu_ret++;
            end else if (idle_junk && $urandom_range(0, 1) == 1) begin
                bus.psum_vld = 1'b1;
            end else if (emu_ret >= K && (n_done + n_abort) < n_started && $urandom_range(0, 2) == 0) begin
                bus.psum_vld = 1'b1;
            end
        end
    end

    initial begin : cmp
        int   d;
        logic live;
        logic e_busy;
        logic e_rd;
        logic e_vld;
        logic e_done;

        chk("pin_sum100", 32'(model(100, 0, 0)), 32'd100);
        chk("pin_relu",   32'(model(4 * 64'hFFFF_FFF0, 0, 0)), 32'd0);
        chk("pin_shift",  32'(model(32'h100, 32'h100, 4)), 32'h20);
`ifdef CONV_SEQ_SAT_EN
        chk("pin_sat",    32'(model(32'h1_0000, 0, 0)), 32'h7FFF);
`else
        chk("pin_trunc",  32'(model(32'h1_0000, 0, 0)), 32'h0000);
`endif
        forever begin
            @(negedge clk);
            if (!rst_q) begin
                chk("rst_busy",     32'(bus.busy),     32'd0);
                chk("rst_tap_rd",   32'(bus.tap_rd),   32'd0);
                chk("rst_tap_addr", 32'(bus.tap_addr), 32'd0);
                chk("rst_dout",     32'(bus.dout),     32'd0);
                chk("rst_dout_vld", 32'(bus.dout_vld), 32'd0);
                chk("rst_done",     32'(bus.done),     32'd0);
            end else begin
                live   = (n_done + n_abort) < n_started;
                d      = cyc - start_cyc;
                e_busy = live && d >= 1;
                e_rd   = live && d >= 1 && d <= K;
                e_vld  = live && d >= K + cur_L + 3;
                e_done = e_vld && bus.dout_rdy;
                chk("busy",     32'(bus.busy),     32'(e_busy));
                chk("tap_rd",   32'(bus.tap_rd),   32'(e_rd));
                if (e_rd) chk("tap_addr", 32'(bus.tap_addr), 32'(d - 1));
                chk("dout_vld", 32'(bus.dout_vld), 32'(e_vld));
                chk("done",     32'(bus.done),     32'(e_done));
                if (e_vld) chk("dout", 32'(bus.dout), 32'(exp_dout));
                if (e_done) n_done++;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic set_tab(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [31:0] e);
        psum_tab[0] = a;
        psum_tab[1] = b;
        psum_tab[2] = c;
        psum_tab[3] = e;
    endtask

    // rmode: 0 ready always, 1 random ready, 2 ready after 3 valid cycles
    task automatic run_pixel(input logic [31:0] bias, input int sh, input int L, input int rmode,
                             input bit mid_start, input bit abort, input bit start_on_done);
        longint acc;
        int     vcnt;
        bit     got;
        idle_junk = 1'b1;
        repeat ($urandom_range(3, 5)) begin
            @(posedge clk);
            #1;
        end
        acc = 0;
        for (int i = 0; i < K; i++) acc += longint'(psum_tab[i]);
        cur_L         = L;
        bus.bias_din  = bias;
        bus.shift_din = 5'(sh);
        exp_dout      = model(acc, longint'(bias), sh);
        bus.start     = 1'b1;
        start_cyc     = cyc;
        n_started++;
        bus.dout_rdy  = (rmode == 0) ? 1'b1 : ((rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0);
        @(posedge clk);
        #1;
        idle_junk = 1'b0;
        vcnt      = 0;
        got       = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            bus.start = (mid_start && cyc == start_cyc + 2);
            if (abort && cyc == start_cyc + K + 1) rst_n = 1'b0;
            case (rmode)
                0:       bus.dout_rdy = 1'b1;
                1:       bus.dout_rdy = 1'($urandom_range(0, 1));
                default: bus.dout_rdy = (vcnt >= 3);
            endcase
            if (start_on_done && rmode == 2 && vcnt >= 3) bus.start = 1'b1;
            @(negedge clk);
            if (bus.dout_vld) vcnt++;
            if (bus.done) got = 1;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                rst_n = 1'b1;
                n_abort++;
                got = 1;
            end
        end
        bus.start = 1'b0;
    endtask

    initial begin : main
        logic [31:0] p [K];
        bus.start     = 1'b0;
        bus.bias_din  = '0;
        bus.shift_din = '0;
        bus.dout_rdy  = 1'b0;
        set_tab(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        set_tab(10, 20, 30, 40);
        run_pixel(0, 0, 1, 0, 0, 0, 0);
        set_tab(32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0);
        run_pixel(0, 0, 2, 0, 0, 0, 0);
        set_tab(32'h40, 32'h40, 32'h40, 32'h40);
        run_pixel(32'h100, 4, 3, 0, 0, 0, 0);
        set_tab(32'h123, 32'h456, 32'h789, 32'h0AB);
        run_pixel(32'h11, 1, 1, 2, 0, 0, 1);
        set_tab(32'h4000, 32'h4000, 32'h4000, 32'h4000);
        run_pixel(0, 0, 2, 0, 0, 0, 0);
        set_tab(5, 6, 7, 8);
        run_pixel(3, 0, 2, 1, 1, 0, 0);
        set_tab(100, 200, 300, 400);
        run_pixel(0, 0, 3, 0, 0, 1, 0);
        set_tab(1, 2, 3, 4);
        run_pixel(32'hFFFF_FFFF, 0, 1, 0, 0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < K; i++) begin
                p[i] = $urandom_range(0, 32'h0003_FFFF);
                if ($urandom_range(0, 3) == 0) p[i] = 32'(-int'(p[i]));
            end
            set_tab(p[0], p[1], p[2], p[3]);
            run_pixel(($urandom_range(0, 4) == 0) ? $urandom : ($urandom & 32'h0000_FFFF),
                      ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 6)),
                      int'($urandom_range(1, 3)), int'($urandom_range(0, 2)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
        end

        repeat (6) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/conv_seq_c6.md
CONV_SEQ_C6 -- requirements
Module: conv_seq_c6

Interface
REQ-001 SHALL have parameter N, default 16: output data width.
REQ-002 SHALL have parameter KTAPS, default 25: kernel taps per output pixel, 6 channels per tap.
REQ-003 SHALL have parameter AW, default 5: tap address width, with 2^AW >= KTAPS.
REQ-004 SHALL have port clk, input, 1: rising-edge clock.
REQ-005 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: one-cycle pulse that begins one output pixel.
REQ-007 SHALL have port busy, output, 1: high from start acceptance until done.
REQ-008 SHALL have port tap_rd, output, 1: read strobe to the input/weight buffers and the 6-lane MAC issue.
REQ-009 SHALL have port tap_addr, output, AW: tap index, qualified by tap_rd.
REQ-010 SHALL have port psum_vld, input, 1: 6-lane partial sum valid from the MAC datapath.
REQ-011 SHALL have port psum_din, input, 32: 6-lane partial sum, two's complement.
REQ-012 SHALL have port bias_din, input, 32: bias, sampled when POST is entered.
REQ-013 SHALL have port shift_din, input, 5: right-shift amount, sampled when POST is entered.
REQ-014 SHALL have port dout, output, N: activated result.
REQ-015 SHALL have port dout_vld, output, 1: result valid.
REQ-016 SHALL have port dout_rdy, input, 1: consumer ready.
REQ-017 SHALL have port done, output, 1: one-cycle pulse on the output handshake.

Function
REQ-018 SHALL implement the states IDLE, ISSUE, DRAIN, POST and OUT.
REQ-019 IDLE SHALL move to ISSUE when start=1, clearing the accumulator, the issue counter and the return counter; busy SHALL go high on the following cycle.
REQ-020 ISSUE SHALL assert tap_rd for exactly KTAPS consecutive cycles, with tap_addr stepping 0..KTAPS-1, then SHALL move to DRAIN.
REQ-021 In every state except IDLE, each psum_vld=1 cycle SHALL add psum_din to the 32-bit accumulator (wrapping) and SHALL increment the return counter, whatever the datapath latency.
REQ-022 psum_vld in the cycle ISSUE exits SHALL still be counted.
REQ-023 DRAIN SHALL move to POST in the cycle after the return counter reaches KTAPS.
REQ-024 POST, one cycle, SHALL compute s = acc + bias_din (32-bit wrap) and r = s logically shifted right by shift_din.
REQ-025 POST SHALL apply ReLU: if s[31]=1 then result = 0, else result = r[N-1:0]; the result SHALL be registered into dout.
REQ-026 OUT SHALL hold dout_vld=1 with dout stable until dout_rdy=1.
REQ-027 On the dout_vld and dout_rdy handshake, done SHALL pulse for one cycle, busy SHALL drop and the state SHALL return to IDLE.
REQ-028 start while busy=1 SHALL be ignored, with no effect on counters or state.
REQ-029 psum_vld in IDLE SHALL be ignored.
REQ-030 psum_vld beyond KTAPS returns SHALL be ignored.
REQ-031 start coincident with a done pulse SHALL be ignored; a new pixel starts only from IDLE.
REQ-032 Minimum latency from start to dout_vld SHALL be KTAPS + L + 3 cycles, where L is the datapath latency.
REQ-033 Throughput SHALL be one pixel per start; operations SHALL NOT overlap.

Reset
REQ-034 When rst_n=0 at a clock edge, the state SHALL become IDLE and busy, tap_rd, dout_vld and done SHALL be 0.
REQ-035 When rst_n=0 at a clock edge, tap_addr, dout, the accumulator and all counters SHALL be 0.
REQ-036 Reset mid-operation SHALL abandon the pixel without emitting dout_vld; late psum_vld returns SHALL be ignored because the state is IDLE.

Configuration
REQ-037 With macro CONV_SEQ_SAT_EN defined, POST SHALL saturate: if s[31]=0 and r > 2^(N-1)-1, then dout = 2^(N-1)-1.
REQ-038 Without CONV_SEQ_SAT_EN, dout SHALL be the truncated r[N-1:0] with no saturation logic.

Verification
REQ-039 KTAPS=4, psums 10,20,30,40, bias 0, shift 0, dout_rdy=1 SHALL give dout=100, one done pulse, and tap_addr 0,1,2,3.
REQ-040 psums 4x 0xFFFFFFF0, bias 0 SHALL give s=-64 and dout=0 (ReLU).
REQ-041 psums 0x40 x4, bias 0x100, shift 4 SHALL give dout=0x20.
REQ-042 dout_rdy low for 3 cycles after dout_vld SHALL hold dout and dout_vld stable; done SHALL pulse only in the handshake cycle.
REQ-043 acc 0x10000, shift 0, N=16 SHALL give dout 0x7FFF with CONV_SEQ_SAT_EN and 0x0000 without it.
REQ-044 start pulsed mid-ISSUE, and rst_n pulsed in DRAIN, SHALL leave the first case's count unchanged and the second idle with no dout_vld; the next start SHALL complete normally.
